// File: rtl/maze_tile_reader.sv
// Raster-order reader for the maze tile RAM. Streams one tile per valid/ready
// handshake with its coordinates and frame markers once generation has finished.
module maze_tile_reader #(
  parameter int unsigned WIDTH       = 30,
  parameter int unsigned HEIGHT      = 40,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned COORD_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   gen_end,
  input  logic                   start,
  input  logic                   continuous,
  output logic [ADDR_WIDTH-1:0]  maze_address,
  input  logic                   maze_address_data,
  output logic                   tile_valid,
  input  logic                   tile_ready,
  output logic                   tile_data,
  output logic [COORD_WIDTH-1:0] tile_x,
  output logic [COORD_WIDTH-1:0] tile_y,
  output logic                   tile_first,
  output logic                   tile_last,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PRESENT} state_t;

  localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(HEIGHT - 1);

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic                   valid_d, data_d, first_d, last_d, busy_d, done_d;
  logic [COORD_WIDTH-1:0] tx_d, ty_d;
  logic                   at_first, at_last;

  // x_q/y_q track the tile currently being fetched or presented
  assign at_first = (x_q == '0) && (y_q == '0);
  assign at_last  = (x_q == X_MAX) && (y_q == Y_MAX);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = maze_address;
    valid_d = tile_valid;
    data_d  = tile_data;
    tx_d    = tile_x;
    ty_d    = tile_y;
    first_d = tile_first;
    last_d  = tile_last;
    done_d  = 1'b0;

    if (state_q != IDLE && !gen_end) begin
      // Abort wins over any handshake in the same cycle
      state_d = IDLE;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && gen_end) begin
            state_d = ISSUE;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          state_d = PRESENT;
          data_d  = maze_address_data;
          tx_d    = x_q;
          ty_d    = y_q;
          first_d = at_first;
          last_d  = at_last;
          valid_d = 1'b1;
        end
        PRESENT: begin
          if (tile_ready) begin
            valid_d = 1'b0;
            if (at_last) begin
              done_d = 1'b1;
              if (continuous) begin
                state_d = ISSUE;
                addr_d  = '0;
                x_d     = '0;
                y_d     = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              state_d = ISSUE;
              addr_d  = maze_address + ADDR_WIDTH'(1);
              if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + COORD_WIDTH'(1);
              end else begin
                x_d = x_q + COORD_WIDTH'(1);
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      maze_address <= '0;
      tile_valid   <= 1'b0;
      tile_data    <= 1'b0;
      tile_x       <= '0;
      tile_y       <= '0;
      tile_first   <= 1'b0;
      tile_last    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      maze_address <= addr_d;
      tile_valid   <= valid_d;
      tile_data    <= data_d;
      tile_x       <= tx_d;
      tile_y       <= ty_d;
      tile_first   <= first_d;
      tile_last    <= last_d;
      busy         <= busy_d;
      frame_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_maze_tile_reader.sv
// Bench for maze_tile_reader: a 4x3 instance for protocol scenarios and the
// default 30x40 instance for a full randomized-ready scan.
module tb_maze_tile_reader;

  localparam int SW = 4, SH = 3, SN = SW * SH;
  localparam int FW = 30, FH = 40, FN = FW * FH;

  logic clock = 1'b0;
  logic reset, gen_end, continuous;

  logic       s_start, s_ready, s_rdata, s_valid, s_data, s_first, s_last, s_busy, s_done;
  logic [3:0] s_addr;
  logic [2:0] s_x, s_y;

  logic        f_start, f_ready, f_rdata, f_valid, f_data, f_first, f_last, f_busy, f_done;
  logic [10:0] f_addr;
  logic [5:0]  f_x, f_y;

  logic s_mem [0:15];
  logic f_mem [0:2047];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, s_done_cnt = 0, f_done_cnt = 0;

  maze_tile_reader #(.WIDTH(SW), .HEIGHT(SH), .ADDR_WIDTH(4), .COORD_WIDTH(3)) u_small (
    .clock(clock), .reset(reset), .gen_end(gen_end), .start(s_start), .continuous(continuous),
    .maze_address(s_addr), .maze_address_data(s_rdata), .tile_valid(s_valid), .tile_ready(s_ready),
    .tile_data(s_data), .tile_x(s_x), .tile_y(s_y), .tile_first(s_first), .tile_last(s_last),
    .busy(s_busy), .frame_done(s_done)
  );

  maze_tile_reader u_full (
    .clock(clock), .reset(reset), .gen_end(gen_end), .start(f_start), .continuous(continuous),
    .maze_address(f_addr), .maze_address_data(f_rdata), .tile_valid(f_valid), .tile_ready(f_ready),
    .tile_data(f_data), .tile_x(f_x), .tile_y(f_y), .tile_first(f_first), .tile_last(f_last),
    .busy(f_busy), .frame_done(f_done)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM models, plus edge and frame_done bookkeeping
  always @(posedge clock) begin
    s_rdata <= s_mem[s_addr];
    f_rdata <= f_mem[f_addr];
    cyc     <= cyc + 1;
    if (s_done) s_done_cnt <= s_done_cnt + 1;
    if (f_done) f_done_cnt <= f_done_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    s_start = 1'b0; f_start = 1'b0; s_ready = 1'b0; f_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_small_start();
    @(negedge clock) s_start = 1'b1;
    @(negedge clock) s_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({s_addr, s_valid, s_data, s_x, s_y, s_first, s_last, s_busy, s_done} !== '0) begin
      n_err++;
      $display("FAIL reset_small: got a=%0d v=%0b d=%0b x=%0d y=%0d f=%0b l=%0b b=%0b fd=%0b, want all 0",
               s_addr, s_valid, s_data, s_x, s_y, s_first, s_last, s_busy, s_done);
    end
    n_cmp++;
    if ({f_addr, f_valid, f_data, f_x, f_y, f_first, f_last, f_busy, f_done} !== '0) begin
      n_err++;
      $display("FAIL reset_full: got a=%0d v=%0b x=%0d y=%0d b=%0b, want all 0",
               f_addr, f_valid, f_x, f_y, f_busy);
    end
  endtask

  task automatic test_raster();
    int t_prev, w, base, gap;
    do_reset();
    gen_end = 1'b1; continuous = 1'b0; s_ready = 1'b1;
    base = s_done_cnt;
    pulse_small_start();
    t_prev = cyc;
    for (int i = 0; i < SN; i++) begin
      w = 0;
      while (!s_valid && w < 10) begin @(negedge clock); w++; end
      n_cmp++;
      if (!s_valid) begin
        n_err++;
        $display("FAIL raster_timeout tile %0d: tile_valid=0, required 1", i);
        return;
      end
      gap = (i == 0) ? 2 : 3;
      n_cmp++;
      if (cyc - t_prev !== gap) begin
        n_err++;
        $display("FAIL raster_spacing tile %0d: got %0d edges, want %0d", i, cyc - t_prev, gap);
      end
      t_prev = cyc;
      n_cmp++;
      if ({s_x, s_y, s_addr, s_data, s_first, s_last} !==
          {3'(i % SW), 3'(i / SW), 4'(i), s_mem[i], i == 0, i == SN - 1}) begin
        n_err++;
        $display("FAIL raster_tile %0d: got x=%0d y=%0d a=%0d d=%0b f=%0b l=%0b, want x=%0d y=%0d a=%0d d=%0b f=%0b l=%0b",
                 i, s_x, s_y, s_addr, s_data, s_first, s_last,
                 i % SW, i / SW, i, s_mem[i], i == 0, i == SN - 1);
      end
      n_cmp++;
      if (s_done !== 1'b0 || s_busy !== 1'b1) begin
        n_err++;
        $display("FAIL raster_busy tile %0d: got busy=%0b done=%0b, want 1/0", i, s_busy, s_done);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (s_done !== 1'b1 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL raster_done: got done=%0b valid=%0b, want 1/0", s_done, s_valid);
    end
    @(negedge clock);
    n_cmp++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_done_cnt - base !== 1) begin
      n_err++;
      $display("FAIL raster_end: got done=%0b busy=%0b pulses=%0d, want 0/0/1",
               s_done, s_busy, s_done_cnt - base);
    end
  endtask

  task automatic test_stall();
    int w, k;
    do_reset();
    gen_end = 1'b1; continuous = 1'b0; s_ready = 1'b1;
    pulse_small_start();
    for (int i = 0; i < SN; i++) begin
      w = 0;
      while (!s_valid && w < 10) begin @(negedge clock); w++; end
      n_cmp++;
      if ({s_valid, s_x, s_y, s_addr, s_data} !== {1'b1, 3'(i % SW), 3'(i / SW), 4'(i), s_mem[i]}) begin
        n_err++;
        $display("FAIL stall_tile %0d: got v=%0b x=%0d y=%0d a=%0d d=%0b, want v=1 x=%0d y=%0d a=%0d d=%0b",
                 i, s_valid, s_x, s_y, s_addr, s_data, i % SW, i / SW, i, s_mem[i]);
      end
      k = (i == 5) ? 5 : int'($urandom_range(0, 2));
      s_ready = 1'b0;
      repeat (k) begin
        @(negedge clock);
        n_cmp++;
        if ({s_valid, s_x, s_y, s_addr, s_data} !== {1'b1, 3'(i % SW), 3'(i / SW), 4'(i), s_mem[i]}) begin
          n_err++;
          $display("FAIL stall_hold %0d: got v=%0b x=%0d y=%0d a=%0d d=%0b, want v=1 x=%0d y=%0d a=%0d d=%0b",
                   i, s_valid, s_x, s_y, s_addr, s_data, i % SW, i / SW, i, s_mem[i]);
        end
      end
      s_ready = 1'b1;
      @(negedge clock);
    end
    n_cmp++;
    if (s_done !== 1'b1) begin
      n_err++;
      $display("FAIL stall_done: got frame_done=%0b, want 1", s_done);
    end
    @(negedge clock);
  endtask

  task automatic test_no_gen_end();
    do_reset();
    gen_end = 1'b0;
    pulse_small_start();
    repeat (6) begin
      @(negedge clock);
      n_cmp++;
      if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_addr !== 4'd0) begin
        n_err++;
        $display("FAIL no_gen_end: got busy=%0b valid=%0b addr=%0d, want 0/0/0", s_busy, s_valid, s_addr);
      end
    end
  endtask

  task automatic test_continuous();
    int w, k, base;
    do_reset();
    gen_end = 1'b1; continuous = 1'b1; s_ready = 1'b1;
    base = s_done_cnt;
    pulse_small_start();
    for (int i = 0; i <= 2 * SN; i++) begin
      k = i % SN;
      w = 0;
      while (!s_valid && w < 10) begin @(negedge clock); w++; end
      n_cmp++;
      if ({s_valid, s_x, s_y, s_addr, s_data, s_first, s_last} !==
          {1'b1, 3'(k % SW), 3'(k / SW), 4'(k), s_mem[k], k == 0, k == SN - 1}) begin
        n_err++;
        $display("FAIL cont_tile %0d: got v=%0b x=%0d y=%0d a=%0d f=%0b l=%0b, want v=1 x=%0d y=%0d a=%0d f=%0b l=%0b",
                 i, s_valid, s_x, s_y, s_addr, s_first, s_last, k % SW, k / SW, k, k == 0, k == SN - 1);
      end
      @(negedge clock);
      if (k == SN - 1) begin
        n_cmp++;
        if (s_done !== 1'b1 || s_busy !== 1'b1) begin
          n_err++;
          $display("FAIL cont_wrap %0d: got done=%0b busy=%0b, want 1/1", i, s_done, s_busy);
        end
      end
    end
    gen_end = 1'b0; continuous = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (s_busy !== 1'b0 || s_done_cnt - base !== 2) begin
      n_err++;
      $display("FAIL cont_pulses: got busy=%0b pulses=%0d, want 0/2", s_busy, s_done_cnt - base);
    end
  endtask

  task automatic test_abort(input int abort_tile);
    int w, base;
    do_reset();
    gen_end = 1'b1; continuous = 1'b0; s_ready = 1'b1;
    base = s_done_cnt;
    pulse_small_start();
    for (int i = 0; i <= abort_tile; i++) begin
      w = 0;
      while (!s_valid && w < 10) begin @(negedge clock); w++; end
      if (i == abort_tile) begin
        n_cmp++;
        if ({s_valid, s_x, s_y} !== {1'b1, 3'(abort_tile % SW), 3'(abort_tile / SW)}) begin
          n_err++;
          $display("FAIL abort_pos: got v=%0b x=%0d y=%0d, want v=1 x=%0d y=%0d",
                   s_valid, s_x, s_y, abort_tile % SW, abort_tile / SW);
        end
        gen_end = 1'b0;
      end
      @(negedge clock);
    end
    n_cmp++;
    if ({s_busy, s_valid, s_first, s_last, s_done} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_%0d: got busy=%0b valid=%0b first=%0b last=%0b done=%0b, want all 0",
               abort_tile, s_busy, s_valid, s_first, s_last, s_done);
    end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (s_done_cnt !== base || s_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_%0d_idle: got pulses=%0d busy=%0b, want 0/0", abort_tile, s_done_cnt - base, s_busy);
    end
  endtask

  task automatic test_reset_mid();
    int w, base;
    do_reset();
    gen_end = 1'b1; continuous = 1'b0; s_ready = 1'b1;
    base = s_done_cnt;
    pulse_small_start();
    w = 0;
    while (!(s_valid && s_addr == 4'd5) && w < 40) begin @(negedge clock); w++; end
    s_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({s_addr, s_valid, s_data, s_x, s_y, s_first, s_last, s_busy, s_done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got a=%0d v=%0b x=%0d y=%0d b=%0b, want all 0",
               s_addr, s_valid, s_x, s_y, s_busy);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_done_cnt !== base) begin
      n_err++;
      $display("FAIL reset_mid_after: got busy=%0b valid=%0b pulses=%0d, want 0/0/0",
               s_busy, s_valid, s_done_cnt - base);
    end
  endtask

  task automatic test_full();
    int w, base;
    do_reset();
    gen_end = 1'b1; continuous = 1'b0; f_ready = 1'b1;
    base = f_done_cnt;
    @(negedge clock) f_start = 1'b1;
    @(negedge clock) f_start = 1'b0;
    for (int i = 0; i < FN; i++) begin
      w = 0;
      while (!f_valid && w < 10) begin @(negedge clock); w++; end
      n_cmp++;
      if ({f_valid, f_x, f_y, f_addr, f_data, f_first, f_last} !==
          {1'b1, 6'(i % FW), 6'(i / FW), 11'(i), f_mem[i], i == 0, i == FN - 1}) begin
        n_err++;
        $display("FAIL full_tile %0d: got v=%0b x=%0d y=%0d a=%0d d=%0b f=%0b l=%0b, want v=1 x=%0d y=%0d a=%0d d=%0b f=%0b l=%0b",
                 i, f_valid, f_x, f_y, f_addr, f_data, f_first, f_last,
                 i % FW, i / FW, i, f_mem[i], i == 0, i == FN - 1);
        if (!f_valid) return;
      end
      do begin
        f_ready = ($urandom_range(0, 3) != 0);
        @(negedge clock);
        if (!f_ready) begin
          n_cmp++;
          if (f_valid !== 1'b1 || f_addr !== 11'(i)) begin
            n_err++;
            $display("FAIL full_hold %0d: got v=%0b a=%0d, want v=1 a=%0d", i, f_valid, f_addr, i);
          end
        end
      end while (!f_ready);
    end
    n_cmp++;
    if (f_done !== 1'b1) begin
      n_err++;
      $display("FAIL full_done: got frame_done=%0b, want 1", f_done);
    end
    @(negedge clock);
    n_cmp++;
    if (f_busy !== 1'b0 || f_done_cnt - base !== 1) begin
      n_err++;
      $display("FAIL full_end: got busy=%0b pulses=%0d, want 0/1", f_busy, f_done_cnt - base);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) s_mem[a] = 1'($urandom_range(0, 1));
    for (int a = 0; a < 2048; a++) f_mem[a] = 1'($urandom_range(0, 1));
    reset = 1'b1; gen_end = 1'b0; continuous = 1'b0;
    s_start = 1'b0; f_start = 1'b0; s_ready = 1'b0; f_ready = 1'b0;

    test_reset();
    test_raster();
    test_stall();
    test_no_gen_end();
    test_continuous();
    test_abort(6);
    test_abort(SN - 1);
    test_reset_mid();
    test_full();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
